// File: rtl/bcd_share_sched.sv
// Time-shared binary-to-BCD converter serving FIR, hour and minute channels.
// One double-dabble engine, round-robin grant, change-triggered plus refresh.
module bcd_share_sched #(
   parameter int REFRESH_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] fir_bin,
   input  logic [4:0] hh_bin,
   input  logic [5:0] mm_bin,
   output logic [3:0] fir_d2,
   output logic [3:0] fir_d1,
   output logic [3:0] fir_d0,
   output logic [3:0] hh_d1,
   output logic [3:0] hh_d0,
   output logic [3:0] mm_d1,
   output logic [3:0] mm_d0,
   output logic [2:0] upd_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [1:0]  r_gnt;
   logic [1:0]  r_last;
   logic [2:0]  r_cnt;
   logic [19:0] r_sh;
   logic [7:0]  r_snap [3];
   logic [2:0]  r_force;

   logic [7:0]  w_val [3];
   logic [2:0]  w_pend;
   logic        w_any;
   logic [1:0]  w_c1;
   logic [1:0]  w_c2;
   logic [1:0]  w_sel;
   logic [11:0] w_adj;
   logic        w_wrap;

   assign w_val[0] = fir_bin;
   assign w_val[1] = {3'b000, hh_bin};
   assign w_val[2] = {2'b00, mm_bin};
   assign w_any    = |w_pend;

   // A channel needs service when its input left the snapshot or it is forced
   always_comb begin
      w_pend = 3'b000;
      for (int i = 0; i < 3; i++) begin
         w_pend[i] = (w_val[i] != r_snap[i]) | r_force[i];
      end
   end

   // Round-robin pick starting after the last granted channel
   always_comb begin
      w_c1 = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
      w_c2 = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
      if (w_pend[w_c1]) begin
         w_sel = w_c1;
      end else if (w_pend[w_c2]) begin
         w_sel = w_c2;
      end else begin
         w_sel = r_last;
      end
   end

   // Add-3 correction of every BCD nibble that is 5 or more
   always_comb begin
      w_adj = r_sh[19:8];
      for (int n = 0; n < 3; n++) begin
         if (r_sh[8+4*n +: 4] >= 4'd5) begin
            w_adj[4*n +: 4] = r_sh[8+4*n +: 4] + 4'd3;
         end
      end
   end

   generate
      if (REFRESH_CYCLES > 0) begin : g_ref
         localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         logic [RW-1:0] r_rcnt;

         assign w_wrap = (r_rcnt == RW'(REFRESH_CYCLES - 1));

         // Free-running refresh period counter
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rcnt <= '0;
            end else if (w_wrap) begin
               r_rcnt <= '0;
            end else begin
               r_rcnt <= r_rcnt + 1'b1;
            end
         end
      end else begin : g_noref
         assign w_wrap = 1'b0;
      end
   endgenerate

   // Scheduler FSM: grant, eight shift-add-3 steps, write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_gnt   <= 2'd0;
         r_last  <= 2'd2;
         r_cnt   <= 3'd0;
         r_sh    <= 20'd0;
         r_snap  <= '{default: 8'h00};
         r_force <= 3'b111;
         fir_d2  <= 4'd0;
         fir_d1  <= 4'd0;
         fir_d0  <= 4'd0;
         hh_d1   <= 4'd0;
         hh_d0   <= 4'd0;
         mm_d1   <= 4'd0;
         mm_d0   <= 4'd0;
         upd_o   <= 3'b000;
         busy_o  <= 1'b0;
      end else begin
         upd_o <= 3'b000;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt          <= w_sel;
                  r_last         <= w_sel;
                  r_snap[w_sel]  <= w_val[w_sel];
                  r_force[w_sel] <= 1'b0;
                  r_sh           <= {12'd0, w_val[w_sel]};
                  r_cnt          <= 3'd0;
                  busy_o         <= 1'b1;
                  r_state        <= S_CONV;
               end
            end
            S_CONV: begin
               r_sh <= {w_adj[10:0], r_sh[7:0], 1'b0};
               if (r_cnt == 3'd7) begin
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            S_DONE: begin
               unique case (r_gnt)
                  2'd0: begin
                     fir_d2 <= r_sh[19:16];
                     fir_d1 <= r_sh[15:12];
                     fir_d0 <= r_sh[11:8];
                  end
                  2'd1: begin
                     hh_d1 <= r_sh[15:12];
                     hh_d0 <= r_sh[11:8];
                  end
                  default: begin
                     mm_d1 <= r_sh[15:12];
                     mm_d0 <= r_sh[11:8];
                  end
               endcase
               upd_o   <= 3'b001 << r_gnt;
               busy_o  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_wrap) begin
            r_force <= 3'b111;
         end
      end
   end

endmodule

// File: tb/tb_bcd_share_sched.sv
// Bench for bcd_share_sched: scoreboard of expected channel updates.
// Two instances: change-driven only, and with a 64-cycle refresh.
module tb_bcd_share_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rst_n_r = 1'b0;
   logic [7:0] fir_bin = 8'd0;
   logic [4:0] hh_bin = 5'd0;
   logic [5:0] mm_bin = 6'd0;
   logic [3:0] fir_d2, fir_d1, fir_d0, hh_d1, hh_d0, mm_d1, mm_d0;
   logic [2:0] upd_o;
   logic       busy_o;

   logic [7:0] fir_r = 8'd9;
   logic [4:0] hh_r = 5'd12;
   logic [5:0] mm_r = 6'd30;
   logic [3:0] rf2, rf1, rf0, rh1, rh0, rm1, rm0;
   logic [2:0] upd_r;
   logic       busy_r;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [2:0]  oh;
      logic [11:0] dig;
   } exp_t;

   exp_t sb[$];
   int   pulse_t[$];

   bcd_share_sched #(.REFRESH_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .fir_bin(fir_bin), .hh_bin(hh_bin), .mm_bin(mm_bin),
      .fir_d2(fir_d2), .fir_d1(fir_d1), .fir_d0(fir_d0),
      .hh_d1(hh_d1), .hh_d0(hh_d0), .mm_d1(mm_d1), .mm_d0(mm_d0),
      .upd_o(upd_o), .busy_o(busy_o)
   );

   bcd_share_sched #(.REFRESH_CYCLES(64)) dut_r (
      .clk(clk), .rst_n(rst_n_r),
      .fir_bin(fir_r), .hh_bin(hh_r), .mm_bin(mm_r),
      .fir_d2(rf2), .fir_d1(rf1), .fir_d0(rf0),
      .hh_d1(rh1), .hh_d0(rh0), .mm_d1(rm1), .mm_d0(rm0),
      .upd_o(upd_r), .busy_o(busy_r)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(int ch, int v);
      exp_t e;
      e.oh  = 3'(1 << ch);
      e.dig = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      return e;
   endfunction

   // Scoreboard monitor: every update pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && upd_o !== 3'b000) begin
         exp_t e;
         logic [11:0] act;
         pulse_t.push_back(cyc);
         checks++;
         case (upd_o)
            3'b001:  act = {fir_d2, fir_d1, fir_d0};
            3'b010:  act = {4'h0, hh_d1, hh_d0};
            3'b100:  act = {4'h0, mm_d1, mm_d0};
            default: act = 12'hxxx;
         endcase
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: upd_o=%b digits=%h at cycle %0d",
                     upd_o, act, cyc);
         end else begin
            e = sb.pop_front();
            if (upd_o !== e.oh || act !== e.dig) begin
               errors++;
               $display("FAIL sb_update: got upd=%b dig=%h, want upd=%b dig=%h",
                        upd_o, act, e.oh, e.dig);
            end
         end
      end
   end

   task automatic wait_drain(input int budget, input string nm);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !busy_o) break;
      end
      checks++;
      if (sb.size() != 0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_timeout: pending=%0d busy=%b, want 0 and 0",
                  nm, sb.size(), busy_o);
      end
   endtask

   task automatic check_zero(input string nm);
      logic [27:0] d;
      d = {fir_d2, fir_d1, fir_d0, hh_d1, hh_d0, mm_d1, mm_d0};
      checks++;
      if (d !== 28'd0) begin
         errors++;
         $display("FAIL %s_digits: got %h want 0", nm, d);
      end
      checks++;
      if (upd_o !== 3'b000) begin
         errors++;
         $display("FAIL %s_upd: got %b want 000", nm, upd_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy: got %b want 0", nm, busy_o);
      end
   endtask

   task automatic check_times(input string nm, input int base, input int n,
                              input int first, input int step);
      checks++;
      if (pulse_t.size() != n) begin
         errors++;
         $display("FAIL %s_count: got %0d pulses want %0d", nm,
                  pulse_t.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (pulse_t[i] - base != first + step * i) begin
               errors++;
               $display("FAIL %s_time%0d: got cycle %0d want %0d", nm, i,
                        pulse_t[i] - base, first + step * i);
            end
         end
      end
   endtask

   task automatic startup(input int f, input int h, input int m,
                          input string nm);
      int base;
      sb.delete();
      pulse_t.delete();
      sb.push_back(mk(0, f));
      sb.push_back(mk(1, h));
      sb.push_back(mk(2, m));
      @(negedge clk);
      rst_n = 1'b1;
      base = cyc;
      wait_drain(60, nm);
      check_times(nm, base, 3, 10, 10);
      repeat (5) @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_busy: got %b want 0", nm, busy_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      startup(0, 0, 0, "startup");
   endtask

   task automatic test_single();
      int base;
      pulse_t.delete();
      fir_bin = 8'd255;
      base = cyc;
      sb.push_back(mk(0, 255));
      wait_drain(30, "single");
      check_times("single", base, 1, 10, 10);
      repeat (12) @(negedge clk);
   endtask

   task automatic test_simul();
      int base;
      pulse_t.delete();
      hh_bin = 5'd23;
      mm_bin = 6'd59;
      fir_bin = 8'd100;
      base = cyc;
      sb.push_back(mk(1, 23));
      sb.push_back(mk(2, 59));
      sb.push_back(mk(0, 100));
      wait_drain(60, "simul");
      check_times("simul", base, 3, 10, 10);
   endtask

   task automatic test_midconv();
      int base;
      pulse_t.delete();
      mm_bin = 6'd45;
      base = cyc;
      sb.push_back(mk(2, 45));
      sb.push_back(mk(2, 7));
      repeat (4) @(negedge clk);
      mm_bin = 6'd7;
      wait_drain(60, "midconv");
      check_times("midconv", base, 2, 10, 10);
   endtask

   task automatic test_reset_mid();
      pulse_t.delete();
      fir_bin = 8'd77;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("rst_mid");
      repeat (2) @(negedge clk);
      startup(77, 23, 7, "restart");
   endtask

   task automatic test_refresh();
      int base;
      int k;
      int want_t[9];
      logic [11:0] want_d[3];
      logic [11:0] act;
      want_t = '{10, 20, 30, 74, 84, 94, 138, 148, 158};
      want_d[0] = 12'h009;
      want_d[1] = 12'h012;
      want_d[2] = 12'h030;
      k = 0;
      @(negedge clk);
      rst_n_r = 1'b1;
      base = cyc;
      for (int i = 1; i <= 190; i++) begin
         @(negedge clk);
         if (upd_r !== 3'b000) begin
            case (upd_r)
               3'b001:  act = {rf2, rf1, rf0};
               3'b010:  act = {4'h0, rh1, rh0};
               3'b100:  act = {4'h0, rm1, rm0};
               default: act = 12'hxxx;
            endcase
            checks++;
            if (k >= 9) begin
               errors++;
               $display("FAIL refresh_extra: upd=%b at cycle %0d",
                        upd_r, cyc - base);
            end else if (cyc - base != want_t[k] ||
                         upd_r !== 3'(1 << (k % 3)) ||
                         act !== want_d[k % 3]) begin
               errors++;
               $display("FAIL refresh_pulse%0d: got t=%0d upd=%b dig=%h, want t=%0d upd=%b dig=%h",
                        k, cyc - base, upd_r, act, want_t[k],
                        3'(1 << (k % 3)), want_d[k % 3]);
            end
            k++;
         end
      end
      checks++;
      if (k != 9) begin
         errors++;
         $display("FAIL refresh_count: got %0d pulses want 9", k);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simul();
      test_midconv();
      test_reset_mid();
      test_refresh();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_share_sched.md
# bcd_share_sched

Time-shared binary-to-BCD scheduler for the display path. It owns one iterative shift-add-3 (double-dabble) converter and serves three requesters: the FIR output byte, the RTC hour and the RTC minute. Requests are issued automatically on value change, with optional periodic refresh. Registered BCD digits go to the existing 7-segment decoders, replacing three parallel converters with one.

## Interface
- REFRESH_CYCLES, default 0: period of the forced re-conversion of all channels, in clk cycles. 0 disables refresh.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fir_bin  in  8  channel 0 value (FIR output).
- hh_bin  in  5  channel 1 value (hours), zero-extended to 8 bits internally.
- mm_bin  in  6  channel 2 value (minutes), zero-extended to 8 bits internally.
- fir_d2, fir_d1, fir_d0  out  4 each  BCD hundreds/tens/units of channel 0.
- hh_d1, hh_d0  out  4 each  BCD tens/units of channel 1.
- mm_d1, mm_d0  out  4 each  BCD tens/units of channel 2.
- upd_o  out  3  one-hot, 1-cycle pulse: the digits of that channel changed on this edge.
- busy_o  out  1  high in CONV and DONE.

## Operation
- Per channel c: snap_c register (8b, last value converted) and force_c flag.
- pending_c = (zero-extended bin_c != snap_c) | force_c. This is combinational.
- States:
  - IDLE: if any pending, grant per round-robin, then go to CONV. Otherwise stay.
  - CONV: 8 iterations.
  - DONE: 1 cycle, then back to IDLE.
- Grant, on the IDLE edge with pending:
  - gnt <= selected channel.
  - snap_gnt <= current input.
  - force_gnt <= 0.
  - shift register <= {12'b0, input}.
  - cnt <= 0.
- Round-robin: the last_gnt pointer resets to 2. The search order is last_gnt+1, last_gnt+2, last_gnt (mod 3). last_gnt <= gnt at grant.
- CONV iteration, per cycle: in the 12-bit BCD field, add 3 to each nibble that is ≥5, then shift the 20-bit {bcd, bin} register left by 1. At cnt==7, go to DONE. Otherwise cnt+1.
- DONE edge:
  - Write the granted channel's digit registers from the BCD field.
  - upd_o <= one-hot(gnt).
  - All other edges: upd_o <= 0.
- Channels 1 and 2 drop the hundreds digit. Out-of-range values (hh>23, mm>59) are converted as-is; range checking is not done here.
- Refresh, when REFRESH_CYCLES>0: a free-running counter 0..REFRESH_CYCLES-1. On wrap, force_0..2 <= 1. If the channel is being granted on that same edge, its force stays set.

## Timing
- Reset values:
  - All digit outputs 0, upd_o 0, busy_o 0.
  - State IDLE, snap_c 0, force_c 1 for all channels. This makes all three convert after reset in the order 0,1,2.
  - Refresh counter 0, last_gnt 2.
- Latency: grant at edge E, iterations at E+1..E+8, digits and upd_o valid after E+9. That is 10 cycles per conversion.
- The next grant is at edge E+10 at the earliest. Back-to-back throughput is one conversion per 10 cycles.
- Input sampling:
  - The input is sampled only at grant.
  - A change during CONV/DONE does not disturb the conversion in progress. The old snapshot result is written, pending reasserts, and the new value is converted when round-robin next reaches that channel.
- An input that changes and returns to snap_c before being granted produces no conversion.
- All three pending at once: served in round-robin order. Worst case 30 cycles until the third channel is updated.
- Reset asserted mid-conversion: immediate return to reset values, partial result discarded.

## Test plan
- Reset release with fir=0, hh=0, mm=0:
  - upd_o pulses 001, 010, 100 at cycles 10, 20, 30 after the first edge.
  - All digits 0.
  - busy_o then low.
- Single channel update: after idle, set fir_bin=255. Within 10 cycles fir_d2/d1/d0 = 2/5/5, upd_o=001 once, no other channel updated.
- Simultaneous change: set hh=23, mm=59 and fir=100 on the same edge, with last_gnt=0.
  - Service order is ch1, ch2, ch0.
  - Result: hh=2/3, mm=5/9, fir=1/0/0.
  - upd_o pulses exactly 10 cycles apart.
- Change mid-conversion: mm_bin 45→7 at cycle 4 of the 45 conversion. mm digits show 4/5 first, then 0/7 after the re-conversion, with two upd_o=100 pulses.
- Refresh with REFRESH_CYCLES=64 and static inputs (fir=9, hh=12, mm=30): after each counter wrap, all three channels re-convert with unchanged digits, one upd_o pulse each.
- Reset asserted at cycle 5 of a conversion:
  - Outputs are 0 immediately.
  - After release, the start-up sequence of the first scenario repeats with the current input values.
